mem_port_arbiter: RTL

//   Shares the single burst memory port (ParamMemory, 4 x 64-bit beats per line) between the
//   I-cache (line read only) and D-cache (line read or write-back). Grants one line transaction
//   at a time, then converts between 256-bit cache lines and 64-bit beats. Sits between the L1

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_burst_buf.sv | 67 ++++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the L1-to-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned BEAT_W     = 64;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BEATS      = LINE_W / BEAT_W;
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

  // Clear the byte-offset bits so the burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_buf.sv
// Cache-line burst buffer: holds one line, tracks the current beat and
// provides next-cycle views so the parent can register its outputs.
module mem_port_arbiter_burst_buf
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic              clr_en,
  input  logic              beat_en,
  input  logic              capture_en,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] beat_nxt_c,
  output logic [LINE_W-1:0] line_nxt_c,
  output logic              last_beat_c
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Load, beat capture and counter advance (wraps after the last beat).
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_en) begin
      line_d = load_line;
    end
    if (clr_en) begin
      cnt_d = '0;
    end else if (beat_en) begin
      if (capture_en) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            line_d[k*BEAT_W +: BEAT_W] = beat_in;
          end
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Beat mux on next-cycle state, so a registered consumer lines up with cnt.
  always_comb begin
    beat_nxt_c = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (cnt_d == CNT_W'(k)) begin
        beat_nxt_c = line_d[k*BEAT_W +: BEAT_W];
      end
    end
  end

  assign line_nxt_c  = line_d;
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  // Buffer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto the single burst
// memory port, one line at a time, round-robin when both are pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  requester_t        last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BEAT_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic              d_req;
  logic              grant_d;
  logic              buf_load;
  logic              buf_clr;
  logic              buf_beat;
  logic              buf_capture;
  logic [BEAT_W-1:0] buf_beat_nxt;
  logic [LINE_W-1:0] buf_line_nxt;
  logic              buf_last;

  mem_port_arbiter_burst_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_en     (buf_load),
    .load_line   (d_wdata),
    .clr_en      (buf_clr),
    .beat_en     (buf_beat),
    .capture_en  (buf_capture),
    .beat_in     (mem_rdata),
    .beat_nxt_c  (buf_beat_nxt),
    .line_nxt_c  (buf_line_nxt),
    .last_beat_c (buf_last)
  );

  // Next-state, grant and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;
    buf_load     = 1'b0;
    buf_clr      = 1'b0;
    buf_beat     = 1'b0;
    buf_capture  = 1'b0;
    d_req        = d_read | d_write;
    grant_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          // D wins when alone, or when both pend and I was served last.
          grant_d = d_req && (!i_read || (last_grant_q == REQ_I));
          buf_clr = 1'b1;
          if (grant_d) begin
            state_d      = d_write ? D_WR : D_RD;
            last_grant_d = REQ_D;
            mem_addr_d   = line_align(d_addr);
            buf_load     = d_write;
          end else begin
            state_d      = I_RD;
            last_grant_d = REQ_I;
            mem_addr_d   = line_align(i_addr);
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        buf_beat    = mem_resp;
        buf_capture = (state_q != D_WR);
        if (mem_resp && buf_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_read_d  = (state_d == I_RD) || (state_d == D_RD);
    mem_write_d = (state_d == D_WR);
    mem_wdata_d = mem_write_d ? buf_beat_nxt : '0;

    if (state_d == DONE) begin
      if (state_q == I_RD) begin
        i_resp_d  = 1'b1;
        i_rdata_d = buf_line_nxt;
      end else if ((state_q == D_RD) || (state_q == D_WR)) begin
        d_resp_d  = 1'b1;
        d_rdata_d = buf_line_nxt;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Illegal requester / memory behaviour.
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
  a_i_hold:    assert property (@(posedge clk) disable iff (!rst) (state_q == I_RD) |-> i_read);
  a_d_hold:    assert property (@(posedge clk) disable iff (!rst)
                                ((state_q == D_RD) || (state_q == D_WR)) |-> d_req);
  a_mem_resp:  assert property (@(posedge clk) disable iff (!rst)
                                mem_resp |-> (mem_read_q || mem_write_q));

endmodule
